// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory arbiter: lane command encodings
// and the arbiter FSM state type.
package mem_pkg;

    localparam logic [1:0] CMD_LOAD  = 2'b01;
    localparam logic [1:0] CMD_STORE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic logic is_mem_cmd(input logic [1:0] cmd);
        return (cmd == CMD_LOAD) || (cmd == CMD_STORE);
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Round-robin picker: first set bit of i_mask strictly after i_last,
// wrapping from lane NLANES-1 back to lane 0.
module rr_pick #(
    parameter int NLANES = 4,
    parameter int IDX_W  = (NLANES > 1) ? $clog2(NLANES) : 1
) (
    input  logic [NLANES-1:0] i_mask,
    input  logic [IDX_W-1:0]  i_last,
    output logic [NLANES-1:0] o_grant,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_any
);

    always_comb begin
        int j;
        j       = 0;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int k = 1; k <= NLANES; k++) begin
            j = (int'(i_last) + k) % NLANES;
            if (!o_any && i_mask[j]) begin
                o_any      = 1'b1;
                o_grant[j] = 1'b1;
                o_idx      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one data-memory port among NLANES MEM slices. Active lanes are
// captured as a wave in IDLE and issued one per cycle in round-robin order.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int NLANES = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NLANES-1:0]              req_valid,
    input  logic [NLANES-1:0][1:0]         req_cmd,
    input  logic [NLANES-1:0][ADDR_W-1:0]  req_addr,
    input  logic [NLANES-1:0][DATA_W-1:0]  req_wdata,
    output logic [NLANES-1:0]              grant,
    output logic [NLANES-1:0]              rsp_valid,
    output logic [DATA_W-1:0]              rsp_rdata,
    output logic                           stall,
    output logic                           mem_en,
    output logic                           mem_we,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [DATA_W-1:0]              mem_wdata,
    input  logic [DATA_W-1:0]              mem_rdata,
    output state_t                         dbg_state
);

    localparam int IDX_W = (NLANES > 1) ? $clog2(NLANES) : 1;

    state_t              r_state;
    state_t              w_next;
    logic [NLANES-1:0]   r_pending;
    logic [NLANES-1:0]   r_rsp_vec;
    logic [IDX_W-1:0]    r_last;

    logic [NLANES-1:0]   w_active;
    logic [NLANES-1:0]   w_pick_grant;
    logic [IDX_W-1:0]    w_pick_idx;
    logic                w_pick_any;
    logic                w_issue;
    logic                w_store;
    logic                w_last_one;

    always_comb begin
        w_active = '0;
        for (int i = 0; i < NLANES; i++) begin
            w_active[i] = req_valid[i] && is_mem_cmd(req_cmd[i]);
        end
    end

    rr_pick #(.NLANES(NLANES), .IDX_W(IDX_W)) u_rr_pick (
        .i_mask  (r_pending),
        .i_last  (r_last),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    // Granted lane's command is read live; anything but a store is a read.
    assign w_issue    = (r_state == ST_SERVE) && w_pick_any;
    assign w_store    = (req_cmd[w_pick_idx] == CMD_STORE);
    assign w_last_one = ((r_pending & ~w_pick_grant) == '0);
    assign dbg_state  = r_state;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (|w_active) w_next = ST_SERVE;
            ST_SERVE: begin
                if (!w_pick_any)     w_next = ST_IDLE;
                else if (w_last_one) w_next = w_store ? ST_IDLE : ST_DRAIN;
            end
            ST_DRAIN: w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        grant     = '0;
        rsp_valid = '0;
        rsp_rdata = '0;
        stall     = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!rst) begin
            stall     = (r_state != ST_IDLE) || (|w_active);
            rsp_valid = r_rsp_vec;
            if (|r_rsp_vec) rsp_rdata = mem_rdata;
            if (w_issue) begin
                grant     = w_pick_grant;
                mem_en    = 1'b1;
                mem_we    = w_store;
                mem_addr  = req_addr[w_pick_idx];
                mem_wdata = req_wdata[w_pick_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
            r_last    <= IDX_W'(NLANES - 1);
            r_rsp_vec <= '0;
        end else begin
            r_state   <= w_next;
            r_rsp_vec <= '0;
            if ((r_state == ST_IDLE) && (|w_active)) r_pending <= w_active;
            if (w_issue) begin
                r_pending <= r_pending & ~w_pick_grant;
                r_last    <= w_pick_idx;
                if (!w_store) r_rsp_vec <= w_pick_grant;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: memory model, grant/response scoreboard and
// scenario tasks for reset, loads, stores, fairness and mid-wave behaviour.
module tb_mem_arbiter;
    import mem_pkg::*;

    localparam int NL = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NL-1:0]         req_valid;
    logic [NL-1:0][1:0]    req_cmd;
    logic [NL-1:0][AW-1:0] req_addr;
    logic [NL-1:0][DW-1:0] req_wdata;
    logic [NL-1:0]         grant;
    logic [NL-1:0]         rsp_valid;
    logic [DW-1:0]         rsp_rdata;
    logic                  stall;
    logic                  mem_en;
    logic                  mem_we;
    logic [AW-1:0]         mem_addr;
    logic [DW-1:0]         mem_wdata;
    logic [DW-1:0]         mem_rdata = '0;
    state_t                dbg_state;

    int total = 0;
    int bad   = 0;
    bit mon_en     = 1'b0;
    bit mon_rsp_en = 1'b1;

    typedef struct packed {
        logic [1:0]    lane;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } gexp_t;

    gexp_t         exp_g_q[$];
    int            exp_rlane_q[$];
    logic [DW-1:0] exp_q[$];

    mem_arbiter #(.NLANES(NL), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_cmd(req_cmd),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .grant(grant), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .stall(stall), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Memory model: read data is the address plus one, one cycle later.
    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= mem_addr + 1;
    end

    // Scoreboard monitor, sampled on the falling edge.
    gexp_t         mon_e;
    logic [NL-1:0] mon_onehot;
    int            mon_lane;
    logic [DW-1:0] mon_data;
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            total++;
            if (grant != '0) begin
                if (exp_g_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_grant got=%b expected none", grant);
                end else begin
                    mon_e      = exp_g_q.pop_front();
                    mon_onehot = 4'b0001 << mon_e.lane;
                    if (grant !== mon_onehot || mem_en !== 1'b1 || mem_we !== mon_e.we ||
                        mem_addr !== mon_e.addr || mem_wdata !== mon_e.wdata) begin
                        bad++;
                        $display("FAIL grant_issue got grant=%b en=%b we=%b addr=%h wdata=%h expected grant=%b en=1 we=%b addr=%h wdata=%h",
                                 grant, mem_en, mem_we, mem_addr, mem_wdata,
                                 mon_onehot, mon_e.we, mon_e.addr, mon_e.wdata);
                    end
                end
            end else if (mem_en !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
                bad++;
                $display("FAIL idle_port got en=%b addr=%h wdata=%h expected 0/0/0",
                         mem_en, mem_addr, mem_wdata);
            end
            total++;
            if (rsp_valid == '0) begin
                if (rsp_rdata !== '0) begin
                    bad++;
                    $display("FAIL idle_rdata got=%h expected 0", rsp_rdata);
                end
            end else if (mon_rsp_en) begin
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_rsp got valid=%b data=%h expected none", rsp_valid, rsp_rdata);
                end else begin
                    mon_lane   = exp_rlane_q.pop_front();
                    mon_data   = exp_q.pop_front();
                    mon_onehot = 4'b0001 << mon_lane;
                    if (rsp_valid !== mon_onehot || rsp_rdata !== mon_data) begin
                        bad++;
                        $display("FAIL load_rsp got valid=%b data=%h expected valid=%b data=%h",
                                 rsp_valid, rsp_rdata, mon_onehot, mon_data);
                    end
                end
            end
        end
    end

    task automatic clear_inputs();
        req_valid = '0;
        req_cmd   = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic drive_lane(input int lane, input logic [1:0] cmd,
                              input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        req_valid[lane] = 1'b1;
        req_cmd[lane]   = cmd;
        req_addr[lane]  = addr;
        req_wdata[lane] = wdata;
    endtask

    task automatic push_grant(input int lane, input logic we,
                              input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        gexp_t e;
        e.lane  = 2'(lane);
        e.we    = we;
        e.addr  = addr;
        e.wdata = wdata;
        exp_g_q.push_back(e);
    endtask

    task automatic push_rsp(input int lane, input logic [DW-1:0] data);
        exp_rlane_q.push_back(lane);
        exp_q.push_back(data);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Runs a wave until stall drops; granted lanes withdraw after their grant.
    task automatic run_wave(input logic [NL-1:0] late_set, input logic [NL-1:0] toggle_clr,
                            output int stall_cycles);
        bit            done;
        logic [NL-1:0] g;
        done         = 1'b0;
        stall_cycles = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            g = grant;
            if (stall) stall_cycles++;
            else done = 1'b1;
            if (!done) begin
                @(posedge clk);
                #1;
                req_valid = req_valid & ~g;
                if (c == 0) begin
                    req_valid = req_valid | late_set;
                    for (int i = 0; i < NL; i++) if (toggle_clr[i]) req_cmd[i] = 2'b00;
                end
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL wave_timeout got stall still high expected stall to drop");
        end
    endtask

    task automatic check_drained(input string name);
        total++;
        if (exp_g_q.size() != 0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drained got grants_left=%0d rsps_left=%0d expected 0/0",
                     name, exp_g_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        for (int i = 0; i < NL; i++) drive_lane(i, CMD_LOAD, 32'h40 * (i + 1), 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if ({grant, rsp_valid, rsp_rdata, stall, mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
                bad++;
                $display("FAIL reset_outputs got grant=%b rsp=%b rdata=%h stall=%b en=%b we=%b addr=%h wdata=%h expected all 0",
                         grant, rsp_valid, rsp_rdata, stall, mem_en, mem_we, mem_addr, mem_wdata);
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (grant !== 4'b0000 || stall !== 1'b1) begin
            bad++;
            $display("FAIL reset_first_cycle got grant=%b stall=%b expected 0000/1", grant, stall);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        total++;
        if (grant !== 4'b0001) begin
            bad++;
            $display("FAIL reset_first_grant got=%b expected 0001", grant);
        end
        @(posedge clk);
        #1;
        do_reset();
    endtask

    task automatic test_four_loads();
        int sc;
        @(posedge clk);
        #1;
        for (int i = 0; i < NL; i++) begin
            drive_lane(i, CMD_LOAD, 32'h10 * (i + 1), 32'h0);
            push_grant(i, 1'b0, 32'h10 * (i + 1), 32'h0);
            push_rsp(i, 32'h10 * (i + 1) + 1);
        end
        run_wave('0, '0, sc);
        total++;
        if (sc != 6) begin
            bad++;
            $display("FAIL four_loads_stall got=%0d expected 6", sc);
        end
        check_drained("four_loads");
    endtask

    task automatic test_store();
        int sc;
        @(posedge clk);
        #1;
        drive_lane(2, CMD_STORE, 32'h8, 32'hDEADBEEF);
        push_grant(2, 1'b1, 32'h8, 32'hDEADBEEF);
        run_wave('0, '0, sc);
        total++;
        if (sc != 2) begin
            bad++;
            $display("FAIL store_stall got=%0d expected 2", sc);
        end
        check_drained("store");
    endtask

    task automatic test_fairness();
        int               sc;
        logic [AW-1:0]    a;
        logic [DW-1:0]    d;
        int               w2[3] = '{0, 1, 3};
        do_reset();
        @(posedge clk);
        #1;
        for (int i = 1; i < NL; i += 2) begin
            a = 32'h200 + 32'(i * 4);
            d = $urandom;
            drive_lane(i, CMD_STORE, a, d);
            push_grant(i, 1'b1, a, d);
        end
        run_wave('0, '0, sc);
        total++;
        if (sc != 3) begin
            bad++;
            $display("FAIL fair_wave1_stall got=%0d expected 3", sc);
        end
        @(posedge clk);
        #1;
        foreach (w2[k]) begin
            a = 32'h400 + 32'($urandom_range(0, 255) * 4);
            drive_lane(w2[k], CMD_LOAD, a, 32'h0);
            push_grant(w2[k], 1'b0, a, 32'h0);
            push_rsp(w2[k], a + 1);
        end
        run_wave('0, '0, sc);
        total++;
        if (sc != 5) begin
            bad++;
            $display("FAIL fair_wave2_stall got=%0d expected 5", sc);
        end
        check_drained("fairness");
    endtask

    task automatic test_mid_wave();
        int sc;
        mon_rsp_en = 1'b0;
        @(posedge clk);
        #1;
        drive_lane(0, CMD_LOAD, 32'h500, 32'h0);
        drive_lane(1, CMD_LOAD, 32'h504, 32'h0);
        drive_lane(2, CMD_LOAD, 32'h508, 32'h0);
        req_valid[2] = 1'b0;
        push_grant(0, 1'b0, 32'h500, 32'h0);
        push_grant(1, 1'b0, 32'h504, 32'h0);
        push_grant(2, 1'b0, 32'h508, 32'h0);
        run_wave(4'b0100, 4'b0001, sc);
        total++;
        if (sc != 7) begin
            bad++;
            $display("FAIL mid_wave_stall got=%0d expected 7", sc);
        end
        check_drained("mid_wave");
        exp_rlane_q.delete();
        exp_q.delete();
        mon_rsp_en = 1'b1;
    endtask

    task automatic test_reset_mid_wave();
        int sc;
        @(posedge clk);
        #1;
        drive_lane(1, CMD_LOAD, 32'h100, 32'h0);
        drive_lane(2, CMD_LOAD, 32'h200, 32'h0);
        push_grant(1, 1'b0, 32'h100, 32'h0);
        @(negedge clk);
        total++;
        if (stall !== 1'b1) begin
            bad++;
            $display("FAIL rmw_latch_stall got=%b expected 1", stall);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        total++;
        if (grant !== 4'b0010) begin
            bad++;
            $display("FAIL rmw_grant got=%b expected 0010", grant);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        req_valid = '0;
        @(negedge clk);
        total++;
        if ({grant, rsp_valid, rsp_rdata, stall, mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
            bad++;
            $display("FAIL rmw_reset_outputs got grant=%b rsp=%b rdata=%h stall=%b en=%b expected all 0",
                     grant, rsp_valid, rsp_rdata, stall, mem_en);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (dbg_state !== ST_IDLE || stall !== 1'b0 || rsp_valid !== '0) begin
            bad++;
            $display("FAIL rmw_after_reset got state=%0d stall=%b rsp=%b expected IDLE/0/0000",
                     dbg_state, stall, rsp_valid);
        end
        check_drained("rmw_abort");
        @(posedge clk);
        #1;
        drive_lane(0, CMD_STORE, 32'h600, 32'hA5A5_0000);
        drive_lane(2, CMD_STORE, 32'h608, 32'h0000_5A5A);
        push_grant(0, 1'b1, 32'h600, 32'hA5A5_0000);
        push_grant(2, 1'b1, 32'h608, 32'h0000_5A5A);
        run_wave('0, '0, sc);
        total++;
        if (sc != 3) begin
            bad++;
            $display("FAIL rmw_next_wave_stall got=%0d expected 3", sc);
        end
        check_drained("rmw_next_wave");
    endtask

    initial begin
        test_reset();
        mon_en = 1'b1;
        test_four_loads();
        test_store();
        test_fairness();
        test_mid_wave();
        test_reset_mid_wave();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have parameter NLANES, default 4, meaning number of MEM slices sharing one data-memory port.
REQ-002 The module SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-003 The module SHALL have parameter DATA_W, default 32, meaning data width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  [NLANES]  lane i has a memory request.
REQ-007 req_cmd  in  [NLANES][2]  lane cmd_type: 2'b01 load, 2'b10 store; other codes are not memory requests.
REQ-008 req_addr  in  [NLANES][ADDR_W]  lane address (ALU result).
REQ-009 req_wdata  in  [NLANES][DATA_W]  lane store data (reg2).
REQ-010 grant  out  [NLANES]  one-hot; lane i is issued this cycle.
REQ-011 rsp_valid  out  [NLANES]  one-hot; load data for lane i is on rsp_rdata.
REQ-012 rsp_rdata  out  DATA_W  load return data.
REQ-013 stall  out  1  freezes the upstream pipeline while a wave is in progress.
REQ-014 mem_en, mem_we  out  1 each  memory port enable and write enable.
REQ-015 mem_addr  out  ADDR_W; mem_wdata  out  DATA_W  memory port address and write data.
REQ-016 mem_rdata  in  DATA_W  memory read data, valid one cycle after a mem_en with mem_we=0.

Function
REQ-017 A lane SHALL be "active" when req_valid[i]=1 and req_cmd[i] is 01 or 10.
REQ-018 The FSM SHALL have states IDLE, SERVE and DRAIN.
- IDLE: if any lane is active, latch the active set into pending_mask and go to SERVE; stall=1 in that same cycle.
REQ-019 In SERVE, every cycle, exactly one pending lane SHALL be granted, chosen round-robin: the first pending lane after last_grant, in modulo NLANES order.
REQ-020 On a grant, the module SHALL drive mem_en=1, mem_we=1 for a store else 0, mem_addr=req_addr[g], mem_wdata=req_wdata[g], and grant[g]=1; all combinationally in the same cycle.
REQ-021 On a grant, the granted lane's pending_mask bit SHALL be cleared and last_grant SHALL be set to g.
REQ-022 For a load granted in cycle N, the module SHALL drive rsp_valid[g]=1 and rsp_rdata=mem_rdata in cycle N+1.
REQ-023 On the last pending grant, the FSM SHALL go to DRAIN if that grant was a load, else to IDLE.
REQ-024 DRAIN SHALL last one cycle, delivering the final load response, then go to IDLE.
REQ-025 stall SHALL be 1 in SERVE, in DRAIN, and in IDLE when any lane is active; otherwise 0.
- Consequence: stall drops in the cycle after the final store grant, or in the cycle after the final load response.
REQ-026 Requests SHALL be sampled only in IDLE; req_* changes during SERVE/DRAIN SHALL NOT alter pending_mask.
- Granted lane inputs SHALL be read live at grant time; upstream holds them because stall=1.
REQ-027 A wave with a single active lane SHALL take 1 grant cycle (plus DRAIN if a load); NLANES active lanes SHALL take NLANES grant cycles.
REQ-028 When no grant is issued, mem_en SHALL be 0 and mem_addr/mem_wdata SHALL be 0.
REQ-029 rsp_rdata SHALL be 0 whenever rsp_valid is all-zero.
REQ-030 last_grant SHALL persist across waves so fairness holds across waves.
- Wrap-around: from lane NLANES-1 the search continues at lane 0.

Reset
REQ-031 On rst=1 at a clock edge, the module SHALL take state=IDLE, pending_mask=0, last_grant=NLANES-1 (lane 0 first), and clear the load-response register.
REQ-032 During and after reset, all outputs SHALL be 0 (grant, rsp_valid, rsp_rdata, stall, mem_*), irrespective of req_*.
REQ-033 Reset mid-wave SHALL abandon pending lanes and drop any in-flight load response; no mem_en SHALL be issued in the reset cycle.

Structure
REQ-034 The cmd_type encodings (CMD_LOAD=2'b01, CMD_STORE=2'b10) and the state enum SHALL live in the shared package mem_pkg.
REQ-035 The round-robin pick SHALL be a sub-module rr_pick (inputs: mask, last pointer; outputs: one-hot grant, index, any).

Verification
REQ-036 Reset: rst=1 with all lanes active for 3 cycles -> all outputs 0; after release, grant[0] arrives in the 2nd cycle.
REQ-037 Four loads, addresses 0x10/0x20/0x30/0x40, memory returns addr+1 -> grants 0,1,2,3 on consecutive cycles; rsp_valid lanes 0..3 one cycle later with 0x11..0x41; stall high for 6 cycles.
REQ-038 Store on lane 2 only, addr 0x8, data 0xDEADBEEF -> one cycle with mem_we=1 and these values; stall high for 2 cycles; no rsp_valid.
REQ-039 Fairness: wave 1 is lanes {1,3}, then wave 2 is lanes {0,1,3} -> grant order 1,3 then 0,1,3.
REQ-040 Mid-wave: lane 0 toggles cmd to 00 during SERVE -> lane 0 is still granted; a new lane going active is not granted until the next wave.
REQ-041 rst asserted in the cycle after a load grant -> no rsp_valid, state IDLE; the next wave starts from lane 0.
